// File: rtl/mips_mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller:
// opcodes, FSM states and datapath select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPE_EX,
    S_ALU_WB,
    S_BRANCH,
    S_ADDI_EX,
    S_ADDI_WB,
    S_JUMP
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] CTL_AND = 3'b000;
  localparam logic [2:0] CTL_OR  = 3'b001;
  localparam logic [2:0] CTL_ADD = 3'b010;
  localparam logic [2:0] CTL_SUB = 3'b110;
  localparam logic [2:0] CTL_SLT = 3'b111;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Unified memory request/ready bundle between the
// controller (master) and the memory (slave).
interface mips_mc_ctrl_if;
  logic mem_req;
  logic mem_write;
  logic i_or_d;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_write,
    output i_or_d,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_write,
    input  i_or_d,
    output mem_ready
  );
endinterface

// File: rtl/mips_mc_ctrl_alu_dec.sv
// ALU control decoder: alu_op + funct -> 3-bit ALU control.
// Lives beside the datapath, not inside the controller.
module mips_alu_dec
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctl
);

  always_comb begin
    alu_ctl = CTL_ADD;
    unique case (1'b1)
      alu_op == ALU_ADD: alu_ctl = CTL_ADD;
      alu_op == ALU_SUB: alu_ctl = CTL_SUB;
      default: begin
        unique case (funct)
          FN_ADD:  alu_ctl = CTL_ADD;
          FN_SUB:  alu_ctl = CTL_SUB;
          FN_AND:  alu_ctl = CTL_AND;
          FN_OR:   alu_ctl = CTL_OR;
          FN_SLT:  alu_ctl = CTL_SLT;
          default: alu_ctl = CTL_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main controller: Moore FSM sequencing the
// shared-ALU/shared-memory datapath, with a memory timeout.
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [5:0]    op,
  input  logic          zero,
  mips_mc_ctrl_if.master mem,
  output logic          ir_write,
  output logic          pc_en,
  output logic [1:0]    pc_src,
  output logic          alu_src_a,
  output logic [1:0]    alu_src_b,
  output logic [1:0]    alu_op,
  output logic          reg_dst,
  output logic          mem_to_reg,
  output logic          reg_write,
  output logic          illegal_op,
  output logic          mem_err
);

  state_t state, state_n;
  logic [WAIT_W-1:0] wait_cnt;

  logic rdy, tmo;
  logic req, wr, iord, irw, pcw, br;
  logic [1:0] pcs, sb, aop;
  logic sa, rd, m2r, rw, ill, err;

  assign rdy = mem.mem_ready;
  assign tmo = !rdy && (wait_cnt == WAIT_W'(MAX_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_n;
      if (state_n != state || err)
        wait_cnt <= '0;
      else if (req && !rdy)
        wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  always_comb begin
    state_n = state;
    req  = 1'b0;
    wr   = 1'b0;
    iord = 1'b0;
    irw  = 1'b0;
    pcw  = 1'b0;
    br   = 1'b0;
    pcs  = PC_ALU;
    sa   = 1'b0;
    sb   = SRCB_REG;
    aop  = ALU_ADD;
    rd   = 1'b0;
    m2r  = 1'b0;
    rw   = 1'b0;
    ill  = 1'b0;
    err  = 1'b0;
    unique case (state)
      S_FETCH: begin
        req = 1'b1;
        sb  = SRCB_FOUR;
        if (rdy) begin
          irw     = 1'b1;
          pcw     = 1'b1;
          state_n = S_DECODE;
        end else if (tmo) begin
          err = 1'b1;
        end
      end
      S_DECODE: begin
        sb = SRCB_IMM_SH;
        unique case (1'b1)
          op == OP_LW || op == OP_SW: state_n = S_MEMADR;
          op == OP_RTYPE:             state_n = S_RTYPE_EX;
          op == OP_BEQ:               state_n = S_BRANCH;
          op == OP_ADDI:              state_n = S_ADDI_EX;
          op == OP_J:                 state_n = S_JUMP;
          default: begin
            ill     = 1'b1;
            state_n = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        sa      = 1'b1;
        sb      = SRCB_IMM;
        state_n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        req  = 1'b1;
        iord = 1'b1;
        if (rdy) begin
          state_n = S_MEMWB;
        end else if (tmo) begin
          err     = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_MEMWB: begin
        rw      = 1'b1;
        m2r     = 1'b1;
        state_n = S_FETCH;
      end
      S_MEMWR: begin
        req  = 1'b1;
        wr   = 1'b1;
        iord = 1'b1;
        if (rdy) begin
          state_n = S_FETCH;
        end else if (tmo) begin
          err     = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_RTYPE_EX: begin
        sa      = 1'b1;
        aop     = ALU_FUNCT;
        state_n = S_ALU_WB;
      end
      S_ALU_WB: begin
        rw      = 1'b1;
        rd      = 1'b1;
        state_n = S_FETCH;
      end
      S_BRANCH: begin
        sa      = 1'b1;
        aop     = ALU_SUB;
        br      = 1'b1;
        pcs     = PC_ALUOUT;
        state_n = S_FETCH;
      end
      S_ADDI_EX: begin
        sa      = 1'b1;
        sb      = SRCB_IMM;
        state_n = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        rw      = 1'b1;
        state_n = S_FETCH;
      end
      S_JUMP: begin
        pcw     = 1'b1;
        pcs     = PC_JUMP;
        state_n = S_FETCH;
      end
      default: state_n = S_FETCH;
    endcase
  end

  // Gate by rst_n so a mid-access reset drops the request at once.
  assign mem.mem_req   = rst_n & req;
  assign mem.mem_write = rst_n & wr;
  assign mem.i_or_d    = rst_n & iord;
  assign ir_write      = rst_n & irw;
  assign pc_en         = rst_n & (pcw | (br & zero));
  assign pc_src        = rst_n ? pcs : 2'b00;
  assign alu_src_a     = rst_n & sa;
  assign alu_src_b     = rst_n ? sb : 2'b00;
  assign alu_op        = rst_n ? aop : 2'b00;
  assign reg_dst       = rst_n & rd;
  assign mem_to_reg    = rst_n & m2r;
  assign reg_write     = rst_n & rw;
  assign illegal_op    = rst_n & ill;
  assign mem_err       = rst_n & err;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: instruction-timeline model checked
// every cycle, plus directed literal checks.
module tb_mips_mc_ctrl;
  import mips_ctrl_pkg::*;

  localparam int MW = 255;
  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3;
  localparam int K_ADDI = 4, K_J = 5, K_ILL = 6;

  typedef struct packed {
    logic req, wr, iord, irw, pcen;
    logic [1:0] pcs;
    logic sa;
    logic [1:0] sb, aop;
    logic rd, m2r, rw, ill, err;
  } ctl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic zero = 1'b0;
  logic ir_write, pc_en, alu_src_a, reg_dst;
  logic mem_to_reg, reg_write, illegal_op, mem_err;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [1:0] d_op;
  logic [5:0] d_fn;
  logic [2:0] d_ctl;

  int checks = 0;
  int failures = 0;

  mips_mc_ctrl_if mif();

  mips_mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero),
    .mem(mif),
    .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal_op(illegal_op), .mem_err(mem_err)
  );

  mips_alu_dec u_dec (
    .alu_op(d_op), .funct(d_fn), .alu_ctl(d_ctl)
  );

  always #5 clk = ~clk;

  function automatic int classify(logic [5:0] o);
    case (o)
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000000: return K_R;
      6'b000100: return K_BEQ;
      6'b001000: return K_ADDI;
      6'b000010: return K_J;
      default:   return K_ILL;
    endcase
  endfunction

  // Total cycles of each instruction with zero-wait memory.
  function automatic int ilen(int k);
    case (k)
      K_LW:  return 5;
      K_BEQ, K_J: return 3;
      K_ILL: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_access(int s, int k);
    return s == 0 || (s == 3 && (k == K_LW || k == K_SW));
  endfunction

  function automatic ctl_t expect_ctl(int s, int k, logic [5:0] o,
                                      logic r, logic z, int w);
    ctl_t e;
    bit tmo;
    e = '0;
    tmo = is_access(s, k) && !r && w == MW;
    if (s == 0) begin
      e.req = 1; e.sb = 2'd1;
      e.irw = r; e.pcen = r; e.err = tmo;
    end else if (s == 1) begin
      e.sb = 2'd3;
      e.ill = classify(o) == K_ILL;
    end else if (s == 2) begin
      case (k)
        K_LW, K_SW, K_ADDI: begin e.sa = 1; e.sb = 2'd2; end
        K_R:   begin e.sa = 1; e.aop = 2'd2; end
        K_BEQ: begin e.sa = 1; e.aop = 2'd1; e.pcs = 2'd1; e.pcen = z; end
        K_J:   begin e.pcen = 1; e.pcs = 2'd2; end
        default: ;
      endcase
    end else if (s == 3) begin
      case (k)
        K_LW:   begin e.req = 1; e.iord = 1; e.err = tmo; end
        K_SW:   begin e.req = 1; e.wr = 1; e.iord = 1; e.err = tmo; end
        K_R:    begin e.rw = 1; e.rd = 1; end
        K_ADDI: e.rw = 1;
        default: ;
      endcase
    end else if (s == 4) begin
      e.rw = 1; e.m2r = 1;
    end
    return e;
  endfunction

  int step, kind, wcnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= 0; kind <= K_ILL; wcnt <= 0;
    end else if (is_access(step, kind) && !mif.mem_ready) begin
      if (wcnt == MW) begin
        step <= 0; wcnt <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
      if (step == 1) kind <= classify(op);
      if (step + 1 == ilen(step == 1 ? classify(op) : kind))
        step <= 0;
      else
        step <= step + 1;
    end
  end

  function automatic ctl_t actual();
    return {mif.mem_req, mif.mem_write, mif.i_or_d, ir_write, pc_en,
            pc_src, alu_src_a, alu_src_b, alu_op, reg_dst,
            mem_to_reg, reg_write, illegal_op, mem_err};
  endfunction

  always @(negedge clk) begin
    ctl_t e, a;
    e = rst_n ? expect_ctl(step, kind, op, mif.mem_ready, zero, wcnt) : '0;
    a = actual();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL model t=%0t step=%0d kind=%0d got=%h want=%h",
               $time, step, kind, a, e);
    end
  end

  task automatic lit(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic setin(logic [5:0] o, logic r, logic z);
    op = o; mif.mem_ready = r; zero = z;
  endtask

  initial begin
    mif.mem_ready = 1'b0;
    d_op = ALU_FUNCT; d_fn = 6'b100010; #1;
    lit("dec_sub", d_ctl, 3'b110);
    d_fn = 6'b101010; #1;
    lit("dec_slt", d_ctl, 3'b111);
    d_op = ALU_SUB; d_fn = 6'b100000; #1;
    lit("dec_beq", d_ctl, 3'b110);

    smp();
    lit("rst_req", mif.mem_req, 0);
    lit("rst_all", actual(), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    setin(6'b100011, 1'b1, 1'b0);
    smp(); lit("lw_c1_irw", ir_write, 1);
    nxt(); nxt(); smp(); lit("lw_c3_srcb", alu_src_b, 2);
    nxt(); nxt(); smp();
    lit("lw_c5_rw", reg_write, 1);
    lit("lw_c5_rdst", reg_dst, 0);
    lit("lw_c5_m2r", mem_to_reg, 1);
    nxt();

    setin(6'b101011, 1'b1, 1'b0);
    nxt(); nxt(); nxt(); smp();
    lit("sw_c4_wr", mif.mem_write, 1);
    nxt();

    setin(6'b000000, 1'b1, 1'b0);
    nxt(); nxt(); smp(); lit("r_c3_aluop", alu_op, 2);
    nxt(); smp();
    lit("r_c4_rw", reg_write, 1);
    lit("r_c4_rdst", reg_dst, 1);
    nxt();

    setin(6'b000100, 1'b1, 1'b1);
    nxt(); nxt(); smp();
    lit("beq1_pcen", pc_en, 1);
    lit("beq1_pcsrc", pc_src, 1);
    nxt();
    setin(6'b000100, 1'b1, 1'b0);
    nxt(); nxt(); smp(); lit("beq0_pcen", pc_en, 0);
    nxt();

    setin(6'b001000, 1'b1, 1'b0);
    nxt(); nxt(); nxt(); smp();
    lit("addi_c4_rw", reg_write, 1);
    nxt();

    setin(6'b000010, 1'b1, 1'b0);
    nxt(); nxt(); smp();
    lit("j_pcsrc", pc_src, 2);
    nxt();

    setin(6'b000010, 1'b0, 1'b0);
    smp(); lit("stall_irw", ir_write, 0);
    nxt(); nxt(); smp(); lit("stall_req3", mif.mem_req, 1);
    nxt(); mif.mem_ready = 1'b1;
    smp(); lit("stall_irw4", ir_write, 1);
    nxt(); nxt(); nxt();

    mif.mem_ready = 1'b0;
    repeat (255) nxt();
    smp();
    lit("tmo_err", mem_err, 1);
    lit("tmo_irw", ir_write, 0);
    nxt(); smp();
    lit("tmo_err_off", mem_err, 0);
    lit("tmo_fetch", mif.mem_req, 1);

    setin(6'b111111, 1'b1, 1'b0);
    nxt(); smp();
    lit("ill_pulse", illegal_op, 1);
    lit("ill_rw", reg_write, 0);
    lit("ill_wr", mif.mem_write, 0);
    nxt(); smp();
    lit("ill_fetch", mif.mem_req, 1);
    lit("ill_off", illegal_op, 0);

    setin(6'b100011, 1'b1, 1'b0);
    nxt(); nxt(); nxt();
    mif.mem_ready = 1'b0;
    smp(); lit("rd_iord", mif.i_or_d, 1);
    #2 rst_n = 1'b0;
    #1 lit("rst_mid", actual(), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    smp();
    lit("rst_fetch", mif.mem_req, 1);
    lit("rst_iord", mif.i_or_d, 0);
    mif.mem_ready = 1'b1;
    repeat (4) nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
